// File: rtl/alt_vipitc131_common_mode_pkg.sv
// Shared types and decode helper for the clocked-video mode switch.
// Binary code k (1..N) selects one-hot bit k-1; code 0 selects nothing.
package alt_vipitc131_common_mode_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } mode_state_t;

   // Widest binary code the decode helper accepts; callers zero-extend into it.
   localparam int MAX_CODE_W = 16;

   // Bit idx of the one-hot decode of code. Codes of any width up to MAX_CODE_W.
   function automatic logic decode_bit(input logic [MAX_CODE_W-1:0] code,
                                       input int unsigned           idx);
      decode_bit = (code == MAX_CODE_W'(idx + 1));
   endfunction

endpackage

// File: rtl/alt_vipitc131_common_to_binary.sv
// One-hot-to-binary status encoder: all-zero -> 0, bit k-1 set -> k.
module alt_vipitc131_common_to_binary #(
   parameter int NO_OF_MODES      = 3,
   parameter int LOG2_NO_OF_MODES = 2
) (
   input  logic [NO_OF_MODES-1:0]      one_hot,
   output logic [LOG2_NO_OF_MODES-1:0] binary
);

   always_comb begin
      binary = '0;
      for (int i = 0; i < NO_OF_MODES; i++) begin
         if (one_hot[i]) binary = LOG2_NO_OF_MODES'(i + 1);
      end
   end

endmodule

// File: rtl/alt_vipitc131_common_to_one_hot.sv
// Combinational binary-to-one-hot decoder: 0 -> all-zero, k -> bit k-1 set.
module alt_vipitc131_common_to_one_hot
   import alt_vipitc131_common_mode_pkg::*;
#(
   parameter int NO_OF_MODES      = 3,
   parameter int LOG2_NO_OF_MODES = 2
) (
   input  logic [LOG2_NO_OF_MODES-1:0] binary,
   output logic [NO_OF_MODES-1:0]      one_hot
);

   always_comb begin
      one_hot = '0;
      for (int i = 0; i < NO_OF_MODES; i++) begin
         one_hot[i] = decode_bit(MAX_CODE_W'(binary), i);
      end
   end

endmodule

// File: rtl/alt_vipitc131_common_mode_switch.sv
// Mode switcher: takes a binary mode request, validates it against mode_enable
// and commits it to a registered one-hot select only at a frame boundary.
module alt_vipitc131_common_mode_switch
   import alt_vipitc131_common_mode_pkg::*;
#(
   parameter int NO_OF_MODES      = 3,
   parameter int LOG2_NO_OF_MODES = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   input  logic [LOG2_NO_OF_MODES-1:0] req_mode,
   output logic                        req_ready,
   input  logic [NO_OF_MODES-1:0]      mode_enable,
   input  logic                        frame_boundary,
   output logic [NO_OF_MODES-1:0]      one_hot_mode,
   output logic [LOG2_NO_OF_MODES-1:0] active_binary,
   output logic                        change_pending,
   output logic                        change_done,
   output logic                        req_error
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both 1; req_mode is sampled only on that edge. req_ready is
   // registered, so holding req_valid while it is 0 never causes an acceptance.

   mode_state_t                 state_q, state_nxt;
   logic [LOG2_NO_OF_MODES-1:0] pending_q, pending_nxt;
   logic [NO_OF_MODES-1:0]      one_hot_q, one_hot_nxt;
   logic [LOG2_NO_OF_MODES-1:0] active_q, active_nxt;
   logic                        ready_q, ready_nxt;
   logic                        pend_flag_q, pend_flag_nxt;
   logic                        done_q, done_nxt;
   logic                        err_q, err_nxt;

   logic [NO_OF_MODES-1:0]      pending_decoded;
   logic                        accept;
   logic                        req_invalid;
   logic                        pending_lost;

   // Enable flag of a nonzero code; codes with no matching mode read as 0.
   function automatic logic mode_usable(input logic [LOG2_NO_OF_MODES-1:0] code,
                                        input logic [NO_OF_MODES-1:0]      en);
      mode_usable = 1'b0;
      for (int i = 0; i < NO_OF_MODES; i++) begin
         if (code == LOG2_NO_OF_MODES'(i + 1)) mode_usable = en[i];
      end
   endfunction

   alt_vipitc131_common_to_one_hot #(
      .NO_OF_MODES      (NO_OF_MODES),
      .LOG2_NO_OF_MODES (LOG2_NO_OF_MODES)
   ) u_to_one_hot (
      .binary  (pending_q),
      .one_hot (pending_decoded)
   );

   assign accept       = req_valid & ready_q;
   assign req_invalid  = (req_mode > LOG2_NO_OF_MODES'(NO_OF_MODES)) ||
                         ((req_mode != '0) && !mode_usable(req_mode, mode_enable));
   assign pending_lost = (pending_q != '0) && !mode_usable(pending_q, mode_enable);

   always_comb begin
      state_nxt     = state_q;
      pending_nxt   = pending_q;
      one_hot_nxt   = one_hot_q;
      active_nxt    = active_q;
      ready_nxt     = ready_q;
      pend_flag_nxt = pend_flag_q;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_nxt     = 1'b1;
            pend_flag_nxt = 1'b0;
            if (accept) begin
               if (req_invalid) begin
                  err_nxt = 1'b1;
               end else if (req_mode == active_q) begin
                  done_nxt = 1'b1;
               end else begin
                  pending_nxt   = req_mode;
                  state_nxt     = PENDING;
                  ready_nxt     = 1'b0;
                  pend_flag_nxt = 1'b1;
               end
            end
         end
         PENDING: begin
            // Losing the pending mode's enable beats a coincident boundary.
            if (pending_lost) begin
               err_nxt       = 1'b1;
               state_nxt     = IDLE;
               ready_nxt     = 1'b1;
               pend_flag_nxt = 1'b0;
            end else if (frame_boundary) begin
               one_hot_nxt   = pending_decoded;
               active_nxt    = pending_q;
               done_nxt      = 1'b1;
               state_nxt     = IDLE;
               ready_nxt     = 1'b1;
               pend_flag_nxt = 1'b0;
            end else begin
               ready_nxt     = 1'b0;
               pend_flag_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         one_hot_q   <= '0;
         active_q    <= '0;
         ready_q     <= 1'b0;
         pend_flag_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         pending_q   <= pending_nxt;
         one_hot_q   <= one_hot_nxt;
         active_q    <= active_nxt;
         ready_q     <= ready_nxt;
         pend_flag_q <= pend_flag_nxt;
         done_q      <= done_nxt;
         err_q       <= err_nxt;
      end
   end

   assign req_ready      = ready_q;
   assign one_hot_mode   = one_hot_q;
   assign active_binary  = active_q;
   assign change_pending = pend_flag_q;
   assign change_done    = done_q;
   assign req_error      = err_q;

endmodule
